// File: rtl/krnl_ctrl_multichan_if.sv
// Host-control and per-channel handshake bundle for krnl_ctrl_multichan.
// master = host/engine side driving start and done, slave = the sequencer.
interface krnl_ctrl_multichan_if #(
  parameter int C_NUM_CHANNELS    = 4,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_CYCLE_CNT_WIDTH = 32
);
  logic                         ap_start;
  logic                         ap_continue;
  logic                         ap_idle;
  logic                         ap_ready;
  logic                         ap_done;
  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes;
  logic [C_NUM_CHANNELS-1:0]    ctrl_channel_mask;
  logic [C_NUM_CHANNELS-1:0]    ch_start;
  logic [C_NUM_CHANNELS-1:0]    ch_done;
  logic [C_XFER_SIZE_WIDTH-1:0] ch_xfer_size;
  logic [C_CYCLE_CNT_WIDTH-1:0] cycle_count;

  modport master (
    output ap_start, ap_continue, ctrl_xfer_size_in_bytes, ctrl_channel_mask, ch_done,
    input  ap_idle, ap_ready, ap_done, ch_start, ch_xfer_size, cycle_count
  );

  modport slave (
    input  ap_start, ap_continue, ctrl_xfer_size_in_bytes, ctrl_channel_mask, ch_done,
    output ap_idle, ap_ready, ap_done, ch_start, ch_xfer_size, cycle_count
  );
endinterface

// File: rtl/krnl_ctrl_multichan.sv
// Multi-channel ap_ctrl sequencer: launches enabled engines, merges their done pulses, times the run.
// Define KRNL_CTRL_CHAIN_EN for ap_ctrl_chain (ap_done held until ap_continue); default is ap_ctrl_hs.
module krnl_ctrl_multichan #(
  parameter int C_NUM_CHANNELS       = 4,
  parameter int C_XFER_SIZE_WIDTH    = 32,
  parameter int C_DEFAULT_XFER_BYTES = 16384,
  parameter int C_CYCLE_CNT_WIDTH    = 32
) (
  input logic                  ap_clk,
  input logic                  areset,
  krnl_ctrl_multichan_if.slave ctrl
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [C_XFER_SIZE_WIDTH-1:0] DEFAULT_XFER =
    C_XFER_SIZE_WIDTH'(C_DEFAULT_XFER_BYTES);
  localparam logic [C_CYCLE_CNT_WIDTH-1:0] CNT_ONE = {{(C_CYCLE_CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                       state_q;
  logic                         ap_start_q;
  logic                         ap_ready_q;
  logic [C_NUM_CHANNELS-1:0]    mask_q;
  logic [C_NUM_CHANNELS-1:0]    done_seen_q;
  logic [C_NUM_CHANNELS-1:0]    ch_start_q;
  logic [C_XFER_SIZE_WIDTH-1:0] xfer_size_q;
  logic [C_CYCLE_CNT_WIDTH-1:0] cycle_cnt_q;

  logic                         start_pulse_d;
  logic [C_NUM_CHANNELS-1:0]    done_seen_d;
  logic                         run_complete_d;
  logic [C_CYCLE_CNT_WIDTH-1:0] cycle_cnt_d;

  // Rising-edge detect on the host start level and merge of this cycle's done pulses
  always_comb begin
    start_pulse_d  = ctrl.ap_start & ~ap_start_q;
    done_seen_d    = done_seen_q | (ctrl.ch_done & mask_q);
    run_complete_d = (done_seen_d == mask_q);
    if (cycle_cnt_q == {C_CYCLE_CNT_WIDTH{1'b1}}) begin
      cycle_cnt_d = cycle_cnt_q;
    end else begin
      cycle_cnt_d = cycle_cnt_q + CNT_ONE;
    end
  end

  // Sequencer state and all registered outputs
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      ap_start_q  <= 1'b0;
      ap_ready_q  <= 1'b0;
      mask_q      <= {C_NUM_CHANNELS{1'b0}};
      done_seen_q <= {C_NUM_CHANNELS{1'b0}};
      ch_start_q  <= {C_NUM_CHANNELS{1'b0}};
      xfer_size_q <= DEFAULT_XFER;
      cycle_cnt_q <= {C_CYCLE_CNT_WIDTH{1'b0}};
    end else begin
      ap_start_q <= ctrl.ap_start;
      ap_ready_q <= 1'b0;
      ch_start_q <= {C_NUM_CHANNELS{1'b0}};
      case (state_q)
        S_IDLE: begin
          if (start_pulse_d) begin
            mask_q      <= ctrl.ctrl_channel_mask;
            ch_start_q  <= ctrl.ctrl_channel_mask;
            ap_ready_q  <= 1'b1;
            done_seen_q <= {C_NUM_CHANNELS{1'b0}};
            cycle_cnt_q <= {C_CYCLE_CNT_WIDTH{1'b0}};
            // A zero request means "use the kernel default size"
            if (ctrl.ctrl_xfer_size_in_bytes == {C_XFER_SIZE_WIDTH{1'b0}}) begin
              xfer_size_q <= DEFAULT_XFER;
            end else begin
              xfer_size_q <= ctrl.ctrl_xfer_size_in_bytes;
            end
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          done_seen_q <= done_seen_d;
          cycle_cnt_q <= cycle_cnt_d;
          state_q     <= S_RUN;
        end
        S_RUN: begin
          done_seen_q <= done_seen_d;
          cycle_cnt_q <= cycle_cnt_d;
          if (run_complete_d) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
`ifdef KRNL_CTRL_CHAIN_EN
          if (ctrl.ap_continue) begin
            state_q <= S_IDLE;
          end
`else
          state_q <= S_IDLE;
`endif
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifndef KRNL_CTRL_CHAIN_EN
  logic unused_continue_d;
  assign unused_continue_d = ctrl.ap_continue;
`endif

  assign ctrl.ap_idle      = (state_q == S_IDLE);
  assign ctrl.ap_done      = (state_q == S_DONE);
  assign ctrl.ap_ready     = ap_ready_q;
  assign ctrl.ch_start     = ch_start_q;
  assign ctrl.ch_xfer_size = xfer_size_q;
  assign ctrl.cycle_count  = cycle_cnt_q;

endmodule

// File: tb/tb_krnl_ctrl_multichan.sv
// Self-checking bench for krnl_ctrl_multichan: directed cases plus randomized runs against a timeline model.
module tb_krnl_ctrl_multichan;

  logic ap_clk = 1'b0;
  logic areset = 1'b1;

  krnl_ctrl_multichan_if #(.C_NUM_CHANNELS(4), .C_XFER_SIZE_WIDTH(32), .C_CYCLE_CNT_WIDTH(32)) bus ();

  krnl_ctrl_multichan #(
    .C_NUM_CHANNELS(4), .C_XFER_SIZE_WIDTH(32),
    .C_DEFAULT_XFER_BYTES(16384), .C_CYCLE_CNT_WIDTH(32)
  ) dut (
    .ap_clk (ap_clk),
    .areset (areset),
    .ctrl   (bus)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;
  logic [3:0]  pat [0:127];
  logic [31:0] prev_cnt  = 32'd0;
  logic [31:0] prev_size = 32'd16384;

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (cycle %0d): observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic clear_pat();
    for (int c = 0; c < 128; c++) pat[c] = 4'b0000;
  endtask

  // Every channel gets one done in [2,tmax], plus sparse random extra pulses
  task automatic fill_pat(input int tmax);
    clear_pat();
    for (int i = 0; i < 4; i++) pat[$urandom_range(tmax, 2)][i] = 1'b1;
    for (int c = 2; c < 60; c++)
      if ($urandom_range(7, 0) == 0) pat[c][$urandom_range(3, 0)] = 1'b1;
  endtask

  // Run completes once every enabled channel has pulsed at least once: latest first pulse
  function automatic int required_k(input logic [3:0] m);
    int k = 0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        int f = -1;
        for (int c = 2; c < 128; c++)
          if (pat[c][i] && f < 0) f = c;
        if (f > k) k = f;
      end
    end
    return k;
  endfunction

  task automatic gap();
    bus.ap_start    = 1'b0;
    bus.ch_done     = 4'b0000;
    bus.ap_continue = 1'b0;
    @(negedge ap_clk);
    chk("gap_idle", -1, {31'd0, bus.ap_idle}, 32'd1);
    tick();
  endtask

  // One full run starting at cycle 0 (start rise); entered and left just after a posedge
  task automatic run_case(input logic [3:0] mask, input logic [31:0] size,
                          input bit hold, input bit jitter, input int cont_dly);
    int k, d, dend, endc;
    logic [31:0] xs, ecnt;
    xs   = (size == 32'd0) ? 32'd16384 : size;
    k    = required_k(mask);
    d    = (mask == 4'b0000) ? 3 : k + 1;
`ifdef KRNL_CTRL_CHAIN_EN
    dend = d + cont_dly;
`else
    dend = d;
`endif
    endc = hold ? 100 : dend + 4;
    for (int c = 0; c <= endc; c++) begin
      if (hold || c == 0) bus.ap_start = 1'b1;
      else if (jitter && c >= 2 && c < d) bus.ap_start = 1'($urandom_range(1, 0));
      else bus.ap_start = 1'b0;
      bus.ctrl_channel_mask       = (c == 0) ? mask : 4'($urandom);
      bus.ctrl_xfer_size_in_bytes = (c == 0) ? size : $urandom;
      bus.ch_done                 = (c < 128) ? pat[c] : 4'b0000;
`ifdef KRNL_CTRL_CHAIN_EN
      bus.ap_continue = (c == dend);
`else
      bus.ap_continue = 1'($urandom_range(1, 0));
`endif
      @(negedge ap_clk);
      chk("ap_idle",  c, {31'd0, bus.ap_idle},  {31'd0, (c == 0 || c > dend)});
      chk("ap_ready", c, {31'd0, bus.ap_ready}, {31'd0, (c == 1)});
      chk("ap_done",  c, {31'd0, bus.ap_done},  {31'd0, (c >= d && c <= dend)});
      chk("ch_start", c, {28'd0, bus.ch_start}, {28'd0, (c == 1) ? mask : 4'b0000});
      ecnt = (c == 0) ? prev_cnt : ((c - 1 < d - 1) ? 32'(c - 1) : 32'(d - 1));
      chk("cycle_count",  c, bus.cycle_count,  ecnt);
      chk("ch_xfer_size", c, bus.ch_xfer_size, (c == 0) ? prev_size : xs);
      tick();
    end
    prev_cnt  = 32'(d - 1);
    prev_size = xs;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] m;
    bus.ap_start = 1'b0;
    bus.ap_continue = 1'b0;
    bus.ctrl_xfer_size_in_bytes = 32'd0;
    bus.ctrl_channel_mask = 4'b0000;
    bus.ch_done = 4'b0000;
    areset = 1'b1;
    tick();
    tick();
    @(negedge ap_clk);
    chk("rst_idle",  0, {31'd0, bus.ap_idle},  32'd1);
    chk("rst_done",  0, {31'd0, bus.ap_done},  32'd0);
    chk("rst_ready", 0, {31'd0, bus.ap_ready}, 32'd0);
    chk("rst_start", 0, {28'd0, bus.ch_start}, 32'd0);
    chk("rst_size",  0, bus.ch_xfer_size,      32'd16384);
    chk("rst_cnt",   0, bus.cycle_count,       32'd0);
    tick();
    areset = 1'b0;
    gap();

    // Four channels finishing at 10/20/30/40, default size
    clear_pat();
    pat[10][0] = 1'b1; pat[20][1] = 1'b1; pat[30][2] = 1'b1; pat[40][3] = 1'b1;
    run_case(4'b1111, 32'd0, 1'b0, 1'b0, 0);
    gap();

    // Sparse mask with unmasked channels pulsing early
    clear_pat();
    pat[5][1] = 1'b1; pat[5][3] = 1'b1; pat[8][0] = 1'b1; pat[12][2] = 1'b1;
    run_case(4'b0101, 32'd4096, 1'b0, 1'b0, 0);
    gap();

    // Empty mask: minimum-length run
    fill_pat(20);
    run_case(4'b0000, 32'd77, 1'b0, 1'b0, 0);
    gap();

    // Start held high long past completion, then released and re-raised
    fill_pat(38);
    run_case(4'b1011, 32'd512, 1'b1, 1'b0, 3);
    gap();
    fill_pat(15);
    run_case(4'b0110, 32'd0, 1'b0, 1'b0, 0);
    gap();

    // Chain handshake: continue seven cycles after ap_done rises
    fill_pat(25);
    run_case(4'b1111, 32'd64, 1'b0, 1'b0, 7);
    gap();

    // Reset during RUN with start held; the held level relaunches afterwards
    bus.ctrl_channel_mask = 4'b1111;
    bus.ctrl_xfer_size_in_bytes = 32'd100;
    bus.ch_done = 4'b0000;
    for (int c = 0; c <= 21; c++) begin
      bus.ap_start    = (c <= 20);
      areset          = (c == 15);
      bus.ch_done     = (c == 18) ? 4'b1111 : 4'b0000;
      bus.ap_continue = (c == 19);
      @(negedge ap_clk);
      if (c == 1)  chk("abort_ready0", c, {31'd0, bus.ap_ready}, 32'd1);
      if (c == 15) chk("abort_busy",   c, {31'd0, bus.ap_idle},  32'd0);
      if (c == 16) begin
        chk("abort_idle", c, {31'd0, bus.ap_idle}, 32'd1);
        chk("abort_done", c, {31'd0, bus.ap_done}, 32'd0);
        chk("abort_cnt",  c, bus.cycle_count,      32'd0);
        chk("abort_size", c, bus.ch_xfer_size,     32'd16384);
      end
      if (c == 17) begin
        chk("relaunch_ready", c, {31'd0, bus.ap_ready}, 32'd1);
        chk("relaunch_start", c, {28'd0, bus.ch_start}, 32'd15);
      end
      if (c == 18) chk("relaunch_size", c, bus.ch_xfer_size, 32'd100);
      if (c == 19) chk("relaunch_done", c, {31'd0, bus.ap_done}, 32'd1);
      if (c == 20) begin
        chk("relaunch_idle", c, {31'd0, bus.ap_idle}, 32'd1);
        chk("relaunch_cnt",  c, bus.cycle_count,      32'd2);
      end
      if (c == 21) chk("no_extra_launch", c, {31'd0, bus.ap_idle}, 32'd1);
      tick();
    end
    prev_cnt  = 32'd2;
    prev_size = 32'd100;
    gap();

    // Randomized runs
    for (int r = 0; r < 20; r++) begin
      fill_pat($urandom_range(45, 2));
      m = 4'($urandom);
      run_case(m, ($urandom_range(3, 0) == 0) ? 32'd0 : $urandom,
               1'b0, 1'b1, $urandom_range(9, 0));
      gap();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
